score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 149 ++++++++++++++
 tb/tb_score_keeper.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Score keeper for the block game: BCD score, lives, high score and a
// four-state game FSM (IDLE / PLAY / HURT / OVER). All outputs are registered.
module score_keeper #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned MAX_LIVES   = 9,
  parameter int unsigned HURT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [3:0] lives,
  output logic [3:0] hi_ones,
  output logic [3:0] hi_tens,
  output logic       playing,
  output logic       hurt,
  output logic       game_over
);

  typedef enum logic [1:0] {StIdle, StPlay, StHurt, StOver} state_e;

  localparam logic [3:0] StartLives = 4'(START_LIVES);
  localparam logic [3:0] MaxLives   = 4'(MAX_LIVES);
  localparam logic [7:0] HurtLoad   = 8'(HURT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d, lives_q, lives_d;
  logic [3:0] hi_ones_q, hi_ones_d, hi_tens_q, hi_tens_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  // Set once start has been seen low after reset; a button held through
  // reset release must not count as a press.
  logic       arm_q, arm_d;
  logic       playing_q, playing_d, hurt_q, hurt_d, over_q, over_d;
  logic       start_edge, bonus;

  // Next-state logic for the game FSM, score, lives and high score.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    lives_d   = lives_q;
    hi_ones_d = hi_ones_q;
    hi_tens_d = hi_tens_q;
    cnt_d     = cnt_q;
    start_d   = start;
    arm_d     = arm_q | ~start;
    bonus     = 1'b0;

    start_edge = start & ~start_q & arm_q;

    case (state_q)
      StIdle: begin
        if (start_edge) state_d = StPlay;
      end
      StPlay: begin
        if (hit && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
            bonus  = 1'b1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
        if (miss) begin
          // A bonus in the same cycle cancels the lost life.
          if (!bonus) lives_d = lives_q - 4'd1;
          if (!bonus && lives_q == 4'd1) begin
            state_d = StOver;
          end else begin
            state_d = StHurt;
            cnt_d   = HurtLoad;
          end
        end else if (bonus && lives_q < MaxLives) begin
          lives_d = lives_q + 4'd1;
        end
      end
      StHurt: begin
        if (cnt_q == 8'd0) state_d = StPlay;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StOver: begin
        if (start_edge) begin
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          lives_d = StartLives;
          state_d = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture the final score into the high score on entry to OVER.
    if (state_q != StOver && state_d == StOver &&
        (tens_d > hi_tens_q || (tens_d == hi_tens_q && ones_d > hi_ones_q))) begin
      hi_tens_d = tens_d;
      hi_ones_d = ones_d;
    end

    playing_d = (state_d == StPlay) || (state_d == StHurt);
    hurt_d    = (state_d == StHurt);
    over_d    = (state_d == StOver);
  end

  // State and registered outputs; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      lives_q   <= StartLives;
      hi_ones_q <= 4'd0;
      hi_tens_q <= 4'd0;
      cnt_q     <= 8'd0;
      start_q   <= 1'b0;
      arm_q     <= 1'b0;
      playing_q <= 1'b0;
      hurt_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      lives_q   <= lives_d;
      hi_ones_q <= hi_ones_d;
      hi_tens_q <= hi_tens_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      arm_q     <= arm_d;
      playing_q <= playing_d;
      hurt_q    <= hurt_d;
      over_q    <= over_d;
    end
  end

  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign lives      = lives_q;
  assign hi_ones    = hi_ones_q;
  assign hi_tens    = hi_tens_q;
  assign playing    = playing_q;
  assign hurt       = hurt_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes hand-computed expected
// output snapshots, a monitor process pops and compares them.
module tb_score_keeper;

  logic       clk, rst, start, hit, miss;
  logic [3:0] score_ones, score_tens, lives, hi_ones, hi_tens;
  logic       playing, hurt, game_over;

  score_keeper dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .score_ones(score_ones),
    .score_tens(score_tens),
    .lives     (lives),
    .hi_ones   (hi_ones),
    .hi_tens   (hi_tens),
    .playing   (playing),
    .hurt      (hurt),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [22:0] exp;
  } chk_t;

  chk_t exp_q[$];
  event pushed;
  int   n_checks = 0;
  int   n_pass   = 0;

  // {tens, ones, lives, hi_tens, hi_ones, playing, hurt, game_over}
  task automatic expect_state(input string name, input int t, input int o, input int l,
                              input int ht, input int ho, input bit p, input bit h,
                              input bit g);
    chk_t c;
    c.name = name;
    c.exp  = {4'(t), 4'(o), 4'(l), 4'(ht), 4'(ho), p, h, g};
    exp_q.push_back(c);
    -> pushed;
  endtask

  // Monitor: compares DUT outputs against every queued expectation.
  initial begin
    chk_t        c;
    logic [22:0] act;
    forever begin
      @(pushed);
      while (exp_q.size() > 0) begin
        c   = exp_q.pop_front();
        act = {score_tens, score_ones, lives, hi_tens, hi_ones, playing, hurt, game_over};
        n_checks++;
        if (act === c.exp) n_pass++;
        else $display("FAIL %s: got t%0d o%0d l%0d hi%0d%0d p%b h%b g%b, expected t%0d o%0d l%0d hi%0d%0d p%b h%b g%b",
                      c.name, act[22:19], act[18:15], act[14:11], act[10:7], act[6:3],
                      act[2], act[1], act[0], c.exp[22:19], c.exp[18:15], c.exp[14:11],
                      c.exp[10:7], c.exp[6:3], c.exp[2], c.exp[1], c.exp[0]);
      end
    end
  end

  // One clock of stimulus; outputs are settled 1 time unit after the edge.
  task automatic step(input bit s, input bit h, input bit m);
    @(negedge clk);
    start = s;
    hit   = h;
    miss  = m;
    @(posedge clk);
    #1;
    hit  = 1'b0;
    miss = 1'b0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  // Non-fatal miss followed by the full invulnerability window.
  task automatic lose_life();
    step(1'b0, 1'b0, 1'b1);
    repeat (64) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0;
    #23;
    expect_state("reset", 0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Game 1: start, 12 hits, ignored start in PLAY.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_state("idle_hit_ignored", 0, 0, 3, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    expect_state("start_play", 0, 0, 3, 0, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    hits(10);
    expect_state("ten_hits_bonus", 1, 0, 4, 0, 0, 1, 0, 0);
    hits(2);
    expect_state("twelve_hits", 1, 2, 4, 0, 0, 1, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    expect_state("start_in_play_ignored", 1, 2, 4, 0, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0);

    // HURT window, with hit/miss injected during it.
    lose_life();
    expect_state("after_first_hurt", 1, 2, 3, 0, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1);
    expect_state("hurt_cycle1", 1, 2, 2, 0, 0, 1, 1, 0);
    for (int i = 2; i <= 64; i++) begin
      step(1'b0, i == 10, i == 20);
      expect_state("hurt_hold", 1, 2, 2, 0, 0, 1, 1, 0);
    end
    step(1'b0, 1'b0, 1'b0);
    expect_state("resume_cycle65", 1, 2, 2, 0, 0, 1, 0, 0);

    // End game 1 at 12.
    lose_life();
    step(1'b0, 1'b0, 1'b1);
    expect_state("over_hi12", 1, 2, 0, 1, 2, 0, 0, 1);
    step(1'b0, 1'b1, 1'b0);
    expect_state("over_holds", 1, 2, 0, 1, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0);
    expect_state("restart2", 0, 0, 3, 1, 2, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0);

    // Game 2: simultaneous hit+miss at 09, then end at 37.
    hits(9);
    expect_state("score09", 0, 9, 3, 1, 2, 1, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    expect_state("hit_miss_same", 1, 0, 3, 1, 2, 1, 1, 0);
    repeat (64) step(1'b0, 1'b0, 1'b0);
    hits(27);
    expect_state("score37", 3, 7, 5, 1, 2, 1, 0, 0);
    repeat (4) lose_life();
    expect_state("lives1", 3, 7, 1, 1, 2, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1);
    expect_state("over_hi37", 3, 7, 0, 3, 7, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0);
    expect_state("restart3", 0, 0, 3, 3, 7, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0);

    // Game 3: end at 25, high score kept.
    hits(25);
    expect_state("score25", 2, 5, 5, 3, 7, 1, 0, 0);
    repeat (4) lose_life();
    step(1'b0, 1'b0, 1'b1);
    expect_state("over_hi_kept", 2, 5, 0, 3, 7, 0, 0, 1);

    // Game 4: saturation of score and lives.
    step(1'b1, 1'b0, 1'b0);
    expect_state("restart4", 0, 0, 3, 3, 7, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    hits(60);
    expect_state("lives_cap_60", 6, 0, 9, 3, 7, 1, 0, 0);
    hits(39);
    expect_state("score99", 9, 9, 9, 3, 7, 1, 0, 0);
    hits(5);
    expect_state("score_sat", 9, 9, 9, 3, 7, 1, 0, 0);

    // Asynchronous reset mid-HURT with start held.
    step(1'b0, 1'b0, 1'b1);
    expect_state("hurt_before_rst", 9, 9, 8, 3, 7, 1, 1, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_state("async_reset", 0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_state("held_start_no_game", 0, 0, 3, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_state("start_after_toggle", 0, 0, 3, 0, 0, 1, 0, 0);

    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
